// File: rtl/hni_txdat_queue.sv
// In-order DAT flit FIFO between the data-buffer read pipeline and hni_txdat.
// Head flit is presented with valid; a won pulse one cycle after capture pops it.

`ifndef CHIE_DAT_FLIT_WIDTH
`define CHIE_DAT_FLIT_WIDTH 392
`endif

module hni_txdat_queue #(
    parameter int unsigned FLIT_W = `CHIE_DAT_FLIT_WIDTH,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdq_push_valid,
    input  logic [FLIT_W-1:0] rdq_push_flit,
    output logic              rdq_push_rdy,
    output logic              dbf_txdat_valid_sx,
    output logic [FLIT_W-1:0] txdat_flit,
    input  logic              txdat_dbf_rdy_s1,
    input  logic              txdat_dbf_won_sx,
    output logic [PTR_W:0]    rdq_count,
    output logic              rdq_err_q
);

    localparam logic [PTR_W:0]   CntFull = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CntOne  = 1;
    localparam logic [PTR_W-1:0] PtrOne  = 1;

    logic [FLIT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              r_err;

    logic              w_nonempty;
    logic              w_push_fire;
    logic              w_pop_fire;
    logic              w_err_set;
    logic [PTR_W:0]    w_count_d;
    logic              w_credit_unused;

    // Credit status is informational only; pops are driven by won alone.
    assign w_credit_unused = txdat_dbf_rdy_s1;

    assign w_nonempty   = (r_count != '0);
    assign rdq_push_rdy = (r_count != CntFull);
    assign w_push_fire  = rdq_push_valid & rdq_push_rdy;
    assign w_pop_fire   = txdat_dbf_won_sx & w_nonempty;
    assign w_err_set    = (rdq_push_valid & ~rdq_push_rdy) | (txdat_dbf_won_sx & ~w_nonempty);

    always_comb begin
        w_count_d = r_count;
        unique case ({w_push_fire, w_pop_fire})
            2'b10:   w_count_d = r_count + CntOne;
            2'b01:   w_count_d = r_count - CntOne;
            default: w_count_d = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push_fire) r_wr_ptr <= r_wr_ptr + PtrOne;
            if (w_pop_fire)  r_rd_ptr <= r_rd_ptr + PtrOne;
            r_count <= w_count_d;
            if (w_err_set)   r_err <= 1'b1;
        end
    end

    // Storage needs no reset: the head output is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push_fire) r_mem[r_wr_ptr] <= rdq_push_flit;
    end

    assign dbf_txdat_valid_sx = w_nonempty;
    assign txdat_flit         = w_nonempty ? r_mem[r_rd_ptr] : '0;
    assign rdq_count          = r_count;
    assign rdq_err_q          = r_err;

endmodule

// File: tb/tb_hni_txdat_queue.sv
// Randomized bench for hni_txdat_queue against a queue-based reference model
// with a small hni_txdat-like consumer (capture, then won one cycle later).

module tb_hni_txdat_queue;

    localparam int unsigned FW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          push_valid;
    logic [FW-1:0] push_flit;
    logic          push_rdy;
    logic          valid;
    logic [FW-1:0] flit;
    logic          credit;
    logic          won;
    logic [PTR_W:0] count;
    logic          err;

    always #5 clk = ~clk;

    hni_txdat_queue #(
        .FLIT_W (FW),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_dut (
        .clk                (clk),
        .rst                (rst),
        .rdq_push_valid     (push_valid),
        .rdq_push_flit      (push_flit),
        .rdq_push_rdy       (push_rdy),
        .dbf_txdat_valid_sx (valid),
        .txdat_flit         (flit),
        .txdat_dbf_rdy_s1   (credit),
        .txdat_dbf_won_sx   (won),
        .rdq_count          (count),
        .rdq_err_q          (err)
    );

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [FW-1:0] m_q[$];
    logic          m_err;
    logic          won_pend;
    int            cyc;
    logic [FW-1:0] rx_q[$];
    int            rx_cyc[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] rx_at(input int i);
        if (i < rx_q.size()) return {32'h0, rx_q[i]};
        return 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction

    task automatic chk_outputs(input string tag);
        int sz;
        sz = m_q.size();
        chk({tag, ".valid"}, valid, (sz != 0));
        chk({tag, ".flit"}, flit, (sz != 0) ? m_q[0] : '0);
        chk({tag, ".count"}, count, sz);
        chk({tag, ".rdy"}, push_rdy, (sz != DEPTH));
        chk({tag, ".err"}, err, m_err);
    endtask

    // One clock: drive inputs, let the consumer decide, update model, check at negedge.
    task automatic step(input logic pv, input logic [FW-1:0] f, input logic cr,
                        input logic xwon);
        logic w, cap;
        int   sz;
        w  = won_pend | xwon;
        sz = m_q.size();
        cap = (sz != 0) && cr && !w;
        push_valid = pv;
        push_flit  = f;
        won        = w;
        credit     = cr;
        if (cap) begin
            rx_q.push_back(flit);
            rx_cyc.push_back(cyc);
        end
        @(posedge clk);
        if (w && sz == 0)      m_err = 1'b1;
        if (pv && sz == DEPTH) m_err = 1'b1;
        if (w && sz != 0)      void'(m_q.pop_front());
        if (pv && sz != DEPTH) m_q.push_back(f);
        won_pend = cap;
        cyc++;
        @(negedge clk);
        chk_outputs("cyc");
    endtask

    task automatic model_clear();
        m_q.delete();
        rx_q.delete();
        rx_cyc.delete();
        m_err    = 1'b0;
        won_pend = 1'b0;
    endtask

    task automatic do_reset();
        push_valid = 1'b0;
        push_flit  = '0;
        won        = 1'b0;
        credit     = 1'b0;
        rst        = 1'b1;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_outputs("reset");
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (m_q.size() == 0 && !won_pend) break;
            step(1'b0, '0, 1'b1, 1'b0);
        end
        chk("drain_done", m_q.size() == 0 && !won_pend, 1'b1);
    endtask

    logic [FW-1:0] d[4];
    int            peak;
    int            idx;
    logic          pv;

    initial begin
        cyc = 0;
        do_reset();
        chk("rst_count", count, 0);
        chk("rst_rdy", push_rdy, 1);

        // A, B, C back to back with credit always available
        d[0] = $urandom; d[1] = $urandom; d[2] = $urandom;
        step(1'b1, d[0], 1'b1, 1'b0);
        chk("abc_valid_rise", valid, 1);
        chk("abc_head_a", flit, d[0]);
        peak = count;
        step(1'b1, d[1], 1'b1, 1'b0);
        if (count > peak) peak = count;
        step(1'b1, d[2], 1'b1, 1'b0);
        if (count > peak) peak = count;
        for (int i = 0; i < 20; i++) begin
            if (m_q.size() == 0 && !won_pend) break;
            step(1'b0, '0, 1'b1, 1'b0);
            if (count > peak) peak = count;
        end
        chk("abc_peak", peak, 2);
        chk("abc_final_count", count, 0);
        chk("abc_rx_n", rx_q.size(), 3);
        for (int i = 0; i < 3; i++) chk("abc_order", rx_at(i), d[i]);
        if (rx_cyc.size() == 3) begin
            chk("abc_space01", rx_cyc[1] - rx_cyc[0], 2);
            chk("abc_space12", rx_cyc[2] - rx_cyc[1], 2);
        end else begin
            chk("abc_space_n", rx_cyc.size(), 3);
        end

        // Fill with no credit, overflow push, then drain
        do_reset();
        for (int i = 0; i < 4; i++) begin
            d[i] = $urandom;
            step(1'b1, d[i], 1'b0, 1'b0);
        end
        chk("full_count", count, 4);
        chk("full_rdy", push_rdy, 0);
        step(1'b1, 32'hEEEE_EEEE, 1'b0, 1'b0);
        chk("ovf_err", err, 1);
        chk("ovf_count", count, 4);
        drain(40);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("ovf_rx_n", rx_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("ovf_order", rx_at(i), d[i]);

        // Held push while full, won arrives
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        step(1'b1, 32'h1234_5678, 1'b1, 1'b0);
        chk("hold_cnt4", count, 4);
        step(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        chk("hold_cnt3", count, 3);
        chk("hold_rdy", push_rdy, 1);
        step(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        chk("hold_cnt4b", count, 4);
        drain(40);
        chk("hold_last", rx_at(rx_q.size() - 1), 32'h1234_5678);

        // Pointer wrap with random gaps
        do_reset();
        idx = 0;
        for (int i = 0; i < 400; i++) begin
            if (rx_q.size() >= 10 && !won_pend) break;
            pv = (idx < 10) && ($urandom_range(0, 3) != 0) && (m_q.size() != DEPTH);
            step(pv, FW'(idx), ($urandom_range(0, 2) != 0), 1'b0);
            if (pv) idx++;
        end
        chk("wrap_rx_n", rx_q.size(), 10);
        for (int i = 0; i < 10; i++) chk("wrap_order", rx_at(i), i);
        chk("wrap_err", err, 0);

        // won pulse while empty
        do_reset();
        step(1'b0, '0, 1'b0, 1'b1);
        chk("uf_count", count, 0);
        chk("uf_err", err, 1);
        step(1'b1, 32'h5A5A_5A5A, 1'b0, 1'b0);
        chk("uf_head", flit, 32'h5A5A_5A5A);

        // Reset mid-drain with three entries
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("mid_count3", count, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_err", err, 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 32'hC0DE_0001, 1'b0, 1'b0);
        chk("mid_new_valid", valid, 1);
        chk("mid_new_head", flit, 32'hC0DE_0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
